open_request_sequencer: RTL and testbench

OPEN_REQUEST_SEQUENCER -- requirements
Module: open_request_sequencer

---
 rtl/open_request_sequencer.sv | 157 +++++++++++++++
 tb/tb_open_request_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/open_request_sequencer.sv
// Door-open request sequencer: debounces a raw button, queues accepted presses and
// issues one open_btn pulse per door cycle, with overflow and timeout supervision.
module open_request_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_CYCLES  = 500000000,
    parameter int unsigned MAX_PENDING     = 7
) (
    input  logic       clk,
    input  logic       rst_a_p,
    input  logic       btn_raw,
    input  logic       door_cycle_complete,
    output logic       open_btn,
    output logic       busy,
    output logic [2:0] pending,
    output logic       overflow,
    output logic       timeout_fault
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      PEND_MAX = 3'(MAX_PENDING);

    // state     | meaning
    // IDLE      | no door cycle in flight; launches when a request is queued
    // ISSUE     | single cycle driving open_btn
    // WAIT_DONE | waiting for door_cycle_complete rising edge or timeout
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic            deb_prev_q;
    logic [DB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            door_prev_q;
    logic [2:0]      pending_q, pending_d;
    logic [2:0]      pend_after_dec;
    logic            overflow_q, overflow_d;
    logic            timeout_q, timeout_d;
    logic            press_evt;
    logic            door_rise;
    logic            launch;

    always_comb begin
        deb_d      = deb_q;
        stab_cnt_d = stab_cnt_q;
        if (sync2_q == deb_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q == DB_LAST) begin
            deb_d      = sync2_q;
            stab_cnt_d = '0;
        end else begin
            stab_cnt_d = stab_cnt_q + DB_W'(1);
        end
    end

    assign press_evt = deb_q & ~deb_prev_q;
    assign door_rise = door_cycle_complete & ~door_prev_q;
    assign launch    = (state_q == IDLE) && (pending_q != 3'd0);

    // Decrement first so a press on the launch edge sees the freed slot.
    always_comb begin
        pend_after_dec = pending_q;
        if (launch) begin
            pend_after_dec = pending_q - 3'd1;
        end
        pending_d  = pend_after_dec;
        overflow_d = overflow_q;
        if (press_evt) begin
            if (pend_after_dec == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pend_after_dec + 3'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d  = WAIT_DONE;
                to_cnt_d = TO_LOAD;
            end
            WAIT_DONE: begin
                if (door_rise) begin
                    state_d = IDLE;
                end else if (to_cnt_q == '0) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        open_btn = 1'b0;
        busy     = 1'b0;
        if (state_q == ISSUE) begin
            open_btn = 1'b1;
        end
        if (state_q != IDLE) begin
            busy = 1'b1;
        end
    end

    assign pending       = pending_q;
    assign overflow      = overflow_q;
    assign timeout_fault = timeout_q;

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_prev_q  <= 1'b0;
            stab_cnt_q  <= '0;
            to_cnt_q    <= '0;
            door_prev_q <= 1'b0;
            pending_q   <= 3'd0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            stab_cnt_q  <= stab_cnt_d;
            to_cnt_q    <= to_cnt_d;
            door_prev_q <= door_cycle_complete;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_open_request_sequencer.sv
// Bench for open_request_sequencer: directed scenarios plus random button/door
// traffic, every cycle compared against a behavioural model of the request queue.
module tb_open_request_sequencer;

    localparam int DEB  = 4;
    localparam int TO   = 20;
    localparam int MAXP = 7;

    logic       clk;
    logic       rst_a_p;
    logic       btn_raw;
    logic       dcc;
    logic       open_btn;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;
    logic       timeout_fault;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    open_request_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO),
        .MAX_PENDING    (MAXP)
    ) dut (
        .clk                (clk),
        .rst_a_p            (rst_a_p),
        .btn_raw            (btn_raw),
        .door_cycle_complete(dcc),
        .open_btn           (open_btn),
        .busy               (busy),
        .pending            (pending),
        .overflow           (overflow),
        .timeout_fault      (timeout_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: button seen through two sample delays, accepted after DEB
    // consecutive disagreeing samples; requests kept as a saturating count.
    bit m_s1 = 0, m_s2 = 0;
    bit m_level = 0, m_level_prev = 0;
    int m_run = 0;
    int m_pend = 0;
    bit m_ovf = 0, m_tof = 0;
    bit m_issuing = 0, m_waiting = 0;
    int m_age = 0;
    bit m_dcc_prev = 0;
    bit m_press, m_launch, m_old_level;
    int m_p;

    always @(posedge clk) begin
        m_press  = m_level && !m_level_prev;
        m_launch = !m_issuing && !m_waiting && (m_pend > 0);
        if (rst_a_p) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_level_prev = 0; m_run = 0;
            m_pend = 0; m_ovf = 0; m_tof = 0; m_issuing = 0; m_waiting = 0;
            m_age = 0; m_dcc_prev = 0;
        end else begin
            m_old_level = m_level;
            if (m_s2 != m_level) begin
                m_run = m_run + 1;
                if (m_run == DEB) begin
                    m_level = m_s2;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_level_prev = m_old_level;
            m_s2 = m_s1;
            m_s1 = btn_raw;

            m_p = m_pend - (m_launch ? 1 : 0);
            if (m_press) begin
                if (m_p == MAXP) m_ovf = 1;
                else m_p = m_p + 1;
            end
            m_pend = m_p;

            if (m_waiting) begin
                m_age = m_age + 1;
                if (dcc && !m_dcc_prev) begin
                    m_waiting = 0;
                end else if (m_age == TO) begin
                    m_waiting = 0;
                    m_tof = 1;
                end
            end else if (m_issuing) begin
                m_issuing = 0;
                m_waiting = 1;
                m_age = 0;
            end else if (m_launch) begin
                m_issuing = 1;
            end
            m_dcc_prev = dcc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("open_btn", 32'(open_btn), 32'(m_issuing));
        chk("busy", 32'(busy), 32'(m_issuing || m_waiting));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("timeout_fault", 32'(timeout_fault), 32'(m_tof));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
            if (open_btn === 1'b1) pulses++;
        end
    endtask

    task automatic do_reset(input int n);
        rst_a_p = 1'b1;
        tick(n);
        rst_a_p = 1'b0;
    endtask

    task automatic press(input int hold, input int gap);
        btn_raw = 1'b1;
        tick(hold);
        btn_raw = 1'b0;
        tick(gap);
    endtask

    task automatic door_edge();
        dcc = 1'b1;
        tick(2);
        dcc = 1'b0;
        tick(1);
    endtask

    initial begin
        rst_a_p = 1'b1;
        btn_raw = 1'b0;
        dcc     = 1'b0;
        tick(3);
        chk("reset_pending", 32'(pending), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_open_btn", 32'(open_btn), 0);
        rst_a_p = 1'b0;

        // glitch shorter than the debounce window
        pulses = 0;
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        tick(12);
        chk("glitch_pulses", pulses, 0);
        chk("glitch_pending", 32'(pending), 0);

        // single clean press, completed by a door edge
        pulses = 0;
        btn_raw = 1'b1;
        tick(10);
        btn_raw = 1'b0;
        tick(2);
        chk("single_busy_wait", 32'(busy), 1);
        door_edge();
        tick(8);
        chk("single_pulses", pulses, 1);
        chk("single_busy_done", 32'(busy), 0);

        // back-to-back presses queued behind an active cycle
        do_reset(2);
        pulses = 0;
        repeat (4) press(4, 4);
        repeat (4) begin
            door_edge();
            tick(4);
        end
        tick(30);
        chk("queue_pulses", pulses, 4);
        chk("queue_pending", 32'(pending), 0);
        chk("queue_busy", 32'(busy), 0);

        // sustained presses with the door never completing
        do_reset(2);
        pulses = 0;
        repeat (14) press(4, 4);
        chk("ovf_pending_sat", 32'(pending), 7);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_timeout_flag", 32'(timeout_fault), 1);
        tick(10);
        chk("ovf_pulses", pulses, 6);

        // reset while waiting with two requests queued
        do_reset(2);
        repeat (3) press(4, 4);
        chk("midrst_pending_before", 32'(pending), 2);
        chk("midrst_busy_before", 32'(busy), 1);
        rst_a_p = 1'b1;
        tick(1);
        rst_a_p = 1'b0;
        chk("midrst_pending", 32'(pending), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_open_btn", 32'(open_btn), 0);
        pulses = 0;
        tick(40);
        chk("midrst_no_pulse", pulses, 0);

        // door level already high before the request is issued
        do_reset(2);
        dcc = 1'b1;
        tick(3);
        press(4, 4);
        tick(6);
        chk("stale_busy_held", 32'(busy), 1);
        dcc = 1'b0;
        tick(2);
        dcc = 1'b1;
        tick(1);
        chk("stale_busy_released", 32'(busy), 0);
        chk("stale_no_timeout", 32'(timeout_fault), 0);
        dcc = 1'b0;
        tick(4);

        // button held through reset yields exactly one press
        btn_raw = 1'b1;
        tick(10);
        do_reset(2);
        pulses = 0;
        tick(12);
        chk("held_rst_pulses", pulses, 1);
        btn_raw = 1'b0;
        door_edge();
        tick(10);

        // random traffic
        do_reset(2);
        for (int i = 0; i < 120; i++) begin
            btn_raw = 1'($urandom_range(0, 1));
            dcc     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) rst_a_p = 1'b1;
            tick($urandom_range(1, 12));
            rst_a_p = 1'b0;
        end
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
